// File: rtl/adder_share_ctrl_if.sv
// Bundle of requester handshakes, operands, results and the shared DW/2-bit adder slice bus.
// Optional subtract ports appear only when ADD_SHARE_SUB_EN is defined.
`timescale 1ns/1ps
interface adder_share_ctrl_if #(
    parameter int DW = 64
);
    logic              req0;
    logic [DW-1:0]     op1_0;
    logic [DW-1:0]     op2_0;
    logic              cin0;
    logic              req1;
    logic [DW-1:0]     op1_1;
    logic [DW-1:0]     op2_1;
    logic              cin1;
`ifdef ADD_SHARE_SUB_EN
    logic              sub0;
    logic              sub1;
`endif
    logic              ack0;
    logic              ack1;
    logic [DW-1:0]     result;
    logic              cout;
    logic              owner;
    logic              busy;
    logic [DW/2-1:0]   add_a;
    logic [DW/2-1:0]   add_b;
    logic              add_cin;
    logic [DW/2-1:0]   add_sum;
    logic              add_cout;

    // Controller side: consumes requests and slice results, drives acks and slice operands.
    modport slave (
`ifdef ADD_SHARE_SUB_EN
        input  sub0, sub1,
`endif
        input  req0, op1_0, op2_0, cin0,
        input  req1, op1_1, op2_1, cin1,
        output ack0, ack1, result, cout, owner, busy,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout
    );

    // Environment side: requesters plus the external adder slice.
    modport master (
`ifdef ADD_SHARE_SUB_EN
        output sub0, sub1,
`endif
        output req0, op1_0, op2_0, cin0,
        output req1, op1_1, op2_1, cin1,
        input  ack0, ack1, result, cout, owner, busy,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout
    );
endinterface

// File: rtl/adder_share_ctrl.sv
// Two-requester sequencer sharing one DW/2-bit adder slice; each add runs as LOW then HIGH pass.
// Optional macro ADD_SHARE_SUB_EN adds per-requester subtract (op1 - op2) support.
`timescale 1ns/1ps
module adder_share_ctrl #(
    parameter int DW = 64
) (
    input  logic               clk,
    input  logic               resetn,
    adder_share_ctrl_if.slave  bus
);
    localparam int H = DW / 2;

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic            owner_q, owner_d;
    logic [DW-1:0]   op1_q, op1_d;
    logic [DW-1:0]   op2_q, op2_d;
    logic            cin_q, cin_d;
    logic            sub_q, sub_d;
    logic [H-1:0]    lo_q, lo_d;
    logic            carry_q, carry_d;
    logic [DW-1:0]   result_q, result_d;
    logic            cout_q, cout_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            busy_q, busy_d;
    logic            win;
    logic            req0_sub;
    logic            req1_sub;

`ifdef ADD_SHARE_SUB_EN
    assign req0_sub = bus.sub0;
    assign req1_sub = bus.sub1;
`else
    assign req0_sub = 1'b0;
    assign req1_sub = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        cin_d    = cin_q;
        sub_d    = sub_q;
        lo_d     = lo_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        win      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the requester that was not served last wins.
                    win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    owner_d = win;
                    last_d  = win;
                    op1_d   = win ? bus.op1_1 : bus.op1_0;
                    op2_d   = win ? bus.op2_1 : bus.op2_0;
                    cin_d   = win ? bus.cin1  : bus.cin0;
                    sub_d   = win ? req1_sub  : req0_sub;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                lo_d    = bus.add_sum;
                carry_d = bus.add_cout;
                state_d = S_HIGH;
            end
            S_HIGH: begin
                result_d = {bus.add_sum, lo_q};
                cout_d   = bus.add_cout;
                ack0_d   = ~owner_q;
                ack1_d   = owner_q;
                state_d  = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            cin_q    <= 1'b0;
            sub_q    <= 1'b0;
            lo_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            cin_q    <= cin_d;
            sub_q    <= sub_d;
            lo_q     <= lo_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
        end
    end

    // Slice operands come only from flops, so the adder sees a clean value per pass.
    always_comb begin
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        case (state_q)
            S_LOW: begin
                bus.add_a   = op1_q[H-1:0];
                bus.add_b   = op2_q[H-1:0] ^ {H{sub_q}};
                bus.add_cin = sub_q | cin_q;
            end
            S_HIGH: begin
                bus.add_a   = op1_q[DW-1:H];
                bus.add_b   = op2_q[DW-1:H] ^ {H{sub_q}};
                bus.add_cin = carry_q;
            end
            default: begin
                bus.add_a   = '0;
                bus.add_b   = '0;
                bus.add_cin = 1'b0;
            end
        endcase
    end

    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.owner  = owner_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl: table of single ops plus tie, round-robin and reset-abort sequences.
// Subtract vectors are added when ADD_SHARE_SUB_EN is defined.
`timescale 1ns/1ps
module tb_adder_share_ctrl;
    localparam int DW = 64;
    localparam int H  = DW / 2;

    logic clk = 1'b0;
    logic resetn;
    always #50 clk = ~clk;

    adder_share_ctrl_if #(.DW(DW)) bus ();
    adder_share_ctrl #(.DW(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    // External adder slice model.
    logic [H:0] slice_sum;
    assign slice_sum    = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{H{1'b0}}, bus.add_cin};
    assign bus.add_sum  = slice_sum[H-1:0];
    assign bus.add_cout = slice_sum[H];

    typedef struct {
        int          sel;
        logic [63:0] a;
        logic [63:0] b;
        logic        c;
        logic        s;
        logic [63:0] r;
        logic        co;
    } vec_t;

    vec_t vt[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_req(input int sel, input logic v);
        if (sel == 0) bus.req0 = v;
        else          bus.req1 = v;
    endtask

    task automatic set_ops(input int sel, input logic [63:0] a, input logic [63:0] b,
                           input logic c, input logic s);
        if (sel == 0) begin
            bus.op1_0 = a; bus.op2_0 = b; bus.cin0 = c;
`ifdef ADD_SHARE_SUB_EN
            bus.sub0 = s;
`endif
        end else begin
            bus.op1_1 = a; bus.op2_1 = b; bus.cin1 = c;
`ifdef ADD_SHARE_SUB_EN
            bus.sub1 = s;
`endif
        end
        if (s) begin end
    endtask

    task automatic do_reset();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // One op from a single requester; operands are scrambled after grant to prove they were latched.
    task automatic run_op(input vec_t v, input string name);
        int   cyc;
        logic got;
        logic a0, a1;
        @(posedge clk);
        #1;
        set_ops(v.sel, v.a, v.b, v.c, v.s);
        set_req(v.sel, 1'b1);
        cyc = 0;
        got = 1'b0;
        a0  = 1'b0;
        a1  = 1'b0;
        while (!got && cyc < 10) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) begin
                check({name, "_busy_low"}, 64'(bus.busy), 64'd1);
                set_ops(v.sel, ~v.a, ~v.b, ~v.c, v.s);
            end
            if (bus.ack0 || bus.ack1) begin
                got = 1'b1;
                a0  = bus.ack0;
                a1  = bus.ack1;
            end
        end
        set_req(v.sel, 1'b0);
        check({name, "_acked"}, 64'(got), 64'd1);
        check({name, "_latency"}, 64'(cyc), 64'd3);
        check({name, "_ack0"}, 64'(a0), 64'(v.sel == 0));
        check({name, "_ack1"}, 64'(a1), 64'(v.sel == 1));
        check({name, "_result"}, bus.result, v.r);
        check({name, "_cout"}, 64'(bus.cout), 64'(v.co));
        check({name, "_owner"}, 64'(bus.owner), 64'(v.sel));
        @(negedge clk);
        check({name, "_ack_pulse"}, 64'({bus.ack0, bus.ack1}), 64'd0);
        check({name, "_idle"}, 64'(bus.busy), 64'd0);
        check({name, "_hold"}, bus.result, v.r);
    endtask

    initial begin
        int   t0, t1, cyc, n;
        int   order[4];
        logic o0, o1;
        vec_t v;

        vt.push_back('{0, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h00000001_00000000, 1'b0});
        vt.push_back('{1, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1});
        vt.push_back('{0, 64'h12345678_9ABCDEF0, 64'h11111111_11111111, 1'b1, 1'b0, 64'h23456789_ABCDF002, 1'b0});
        vt.push_back('{1, 64'h80000000_00000000, 64'h80000000_00000000, 1'b0, 1'b0, 64'h0, 1'b1});
        vt.push_back('{0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1'b1});
        vt.push_back('{1, 64'h00000000_7FFFFFFF, 64'h00000000_80000000, 1'b1, 1'b0, 64'h00000001_00000000, 1'b0});
`ifdef ADD_SHARE_SUB_EN
        vt.push_back('{0, 64'h00000001_00000000, 64'h1, 1'b0, 1'b1, 64'h00000000_FFFFFFFF, 1'b1});
        vt.push_back('{1, 64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b0});
        vt.push_back('{0, 64'h5, 64'h5, 1'b0, 1'b1, 64'h0, 1'b1});
`endif

        resetn = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        set_ops(0, 64'h0, 64'h0, 1'b0, 1'b0);
        set_ops(1, 64'h0, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_ack", 64'({bus.ack0, bus.ack1}), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_owner", 64'(bus.owner), 64'd0);
        check("rst_slice", 64'({bus.add_a, bus.add_cin}), 64'd0);
        resetn = 1'b1;

        // Tie right after reset: requester 0 first, then 1 four cycles later.
        @(posedge clk);
        #1;
        set_ops(0, 64'd5, 64'd6, 1'b0, 1'b0);
        set_ops(1, 64'd7, 64'd8, 1'b0, 1'b0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        t0 = -1; t1 = -1; o0 = 1'b1; o1 = 1'b0; cyc = 0;
        while (t1 < 0 && cyc < 14) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.ack0) begin
                t0 = cyc; o0 = bus.owner; bus.req0 = 1'b0;
                check("tie_res0", bus.result, 64'd11);
            end
            if (bus.ack1) begin
                t1 = cyc; o1 = bus.owner; bus.req1 = 1'b0;
                check("tie_res1", bus.result, 64'd15);
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check("tie_t0", 64'(t0), 64'd3);
        check("tie_t1", 64'(t1), 64'd7);
        check("tie_owner0", 64'(o0), 64'd0);
        check("tie_owner1", 64'(o1), 64'd1);

        foreach (vt[i]) run_op(vt[i], $sformatf("vec%0d", i));

        // Round-robin with both requests held for four ops.
        do_reset();
        @(posedge clk);
        #1;
        set_ops(0, 64'd1, 64'd1, 1'b0, 1'b0);
        set_ops(1, 64'd2, 64'd2, 1'b0, 1'b0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 24) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.ack0 && bus.ack1) check("rr_double_ack", 64'd1, 64'd0);
            else if (bus.ack0 || bus.ack1) begin
                order[n] = int'(bus.owner);
                check($sformatf("rr_ack_owner%0d", n), 64'(bus.ack1), 64'(bus.owner));
                n++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check("rr_count", 64'(n), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < n) check($sformatf("rr_order%0d", i), 64'(order[i]), 64'(i % 2));

        // Reset asserted while the op sits in HIGH.
        do_reset();
        @(posedge clk);
        #1;
        set_ops(0, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0, 1'b0);
        bus.req0 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("abort_in_high", 64'(bus.add_a), 64'h12345678);
        resetn = 1'b0;
        bus.req0 = 1'b0;
        #1;
        check("abort_result", bus.result, 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_slice", 64'(bus.add_a), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1 || bus.busy) n++;
        end
        check("abort_no_ack", 64'(n), 64'd0);
        check("abort_result_hold", bus.result, 64'd0);
        v = '{0, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0, 1'b0, 64'h2468ACF1_3579BDE0, 1'b0};
        run_op(v, "after_abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
